// File: rtl/lb_clock_counter.sv
// Programmable tick generator: emits a one-cycle done pulse every `value` clk cycles.
// A value of zero disables the counter; a value of one pulses every cycle.
module lb_clock_counter #(
   parameter int unsigned WIDTH = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] value,
   output logic             done
);

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      cnt_d  = '0;
      done_d = 1'b0;
      if (value == '0) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (cnt_q >= value - One) begin
         // >= rather than == so a value lowered below cnt wraps on the next edge
         cnt_d  = '0;
         done_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + One;
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_lb_clock_counter.sv
// Directed bench for lb_clock_counter: vector table plus multi-cycle sequences
// (period, mid-count reset, dynamic shrink, maximum terminal count on a narrow instance).
module tb_lb_clock_counter;

   localparam int unsigned WIDTH  = 20;
   localparam int unsigned SWIDTH = 8;

   logic              clk;
   logic              reset;
   logic [WIDTH-1:0]  value;
   logic              done;

   logic              reset_s;
   logic [SWIDTH-1:0] value_s;
   logic              done_s;

   int unsigned n_total;
   int unsigned n_pass;

   lb_clock_counter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .done  (done)
   );

   lb_clock_counter #(.WIDTH(SWIDTH)) dut_small (
      .clk   (clk),
      .reset (reset_s),
      .value (value_s),
      .done  (done_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic [WIDTH-1:0] val;
      logic             exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: done=%b expected %b at %0t", name, act, exp, $time);
   endtask

   // Apply inputs just after an edge, then sample 1 ns after the following edge.
   task automatic step(input logic rst, input logic [WIDTH-1:0] val);
      reset = rst;
      value = val;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rst, input int unsigned val, input logic exp, input int n);
      for (int i = 0; i < n; i++) vecs.push_back('{rst, WIDTH'(val), exp});
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b0;
      value   = '0;
      reset_s = 1'b0;
      value_s = 8'd255;

      // Reset hold, then value=3 period, value=1 always-on, value=0 off,
      // value=2, one-edge reset, value=4.
      add(1'b0, 10, 1'b0, 5);
      add(1'b1, 3, 1'b0, 2);
      add(1'b1, 3, 1'b1, 1);
      add(1'b1, 3, 1'b0, 2);
      add(1'b1, 3, 1'b1, 1);
      add(1'b1, 1, 1'b1, 3);
      add(1'b1, 0, 1'b0, 3);
      add(1'b1, 2, 1'b0, 1);
      add(1'b1, 2, 1'b1, 1);
      add(1'b1, 2, 1'b0, 1);
      add(1'b0, 2, 1'b0, 1);
      add(1'b1, 4, 1'b0, 3);
      add(1'b1, 4, 1'b1, 1);
      add(1'b1, 4, 1'b0, 3);
      add(1'b1, 4, 1'b1, 1);

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].val);
         chk($sformatf("vec%0d", i), done, vecs[i].exp_done);
      end

      // Basic period: value=10, first pulse on the 10th edge after release.
      step(1'b0, 10);
      chk("period_rst", done, 1'b0);
      for (int e = 1; e <= 205; e++) begin
         step(1'b1, 10);
         chk($sformatf("period_e%0d", e), done, (e % 10) == 0);
      end

      // Mid-count reset (5 edges into a period): new phase starts at release.
      step(1'b0, 10);
      chk("midrst_low", done, 1'b0);
      for (int e = 1; e <= 20; e++) begin
         step(1'b1, 10);
         chk($sformatf("midrst_e%0d", e), done, (e % 10) == 0);
      end

      // Dynamic shrink: cnt reaches 50 under value=100, then value=20.
      step(1'b0, 100);
      for (int e = 1; e <= 50; e++) begin
         step(1'b1, 100);
         chk($sformatf("shrink_pre%0d", e), done, 1'b0);
      end
      step(1'b1, 20);
      chk("shrink_wrap", done, 1'b1);
      for (int e = 1; e <= 40; e++) begin
         step(1'b1, 20);
         chk($sformatf("shrink_e%0d", e), done, (e % 20) == 0);
      end

      // Maximum terminal count on the narrow instance: 2^8-1 cycles per pulse.
      step(1'b0, 0);
      reset_s = 1'b1;
      for (int e = 1; e <= 520; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("max_e%0d", e), done_s, (e % 255) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
